terminal_tx: RTL and testbench
==============================

# terminal_tx

Output-device end of the OUTR path. The block accepts the byte the CPU writes on an OUT instruction and owns the FGO (output flag) handshake. It serializes the byte onto a single asynchronous serial line (8N1-style: start bit, data bits LSB first, one stop bit). It sits between the OUT-instruction datapath (AC low byte) and the terminal pin, and presents FGO to the control unit for SKO and interrupt decisions.

## Interface
Parameters:
- u, 8: character width in bits, matching the OUTR/INPR width.
- CLKS_PER_BIT, 16: clock cycles per serial bit. Legal range is ≥ 2; behaviour below 2 is undefined.

Ports:
- CLK, input, 1: single clock. All state changes on posedge CLK.
- RST, input, 1: reset, asynchronous and active-high.
- Data_in, input, u: character to transmit (AC[u-1:0]).
- LD, input, 1: OUT-instruction strobe. Requests transmission of Data_in.
- FGO, output, 1: output flag. 1 = ready for a new character; 0 = transmission in progress.
- TX, output, 1: serial line. Idles at 1.
- BUSY, output, 1: equals ~FGO. Provided for status/debug.

## Operation
- Registers:
  - shift buffer, u bits.
  - bit-period counter, $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 then wraps.
  - bit index, counts 0..u-1.
  - state.
  - FGO, TX.
- Reset (RST=1, any time, including mid-frame): takes effect immediately.
  - state=IDLE, FGO=1, TX=1, BUSY=0.
  - Counters and shift buffer = 0.
  - Any frame in progress is abandoned; no partial stop bit is emitted.
- States:
  - IDLE:
    - TX=1, FGO=1.
    - On LD=1: shift buffer←Data_in, TX←0, FGO←0, counters←0, go to START.
  - START:
    - TX held 0 for CLKS_PER_BIT cycles.
    - On the last cycle (counter=CLKS_PER_BIT-1): TX←buffer[0], go to DATA.
  - DATA:
    - Each bit is held CLKS_PER_BIT cycles.
    - At the end of each bit period: shift buffer right by one, TX←next bit, bit index+1.
    - After bit u-1 completes: TX←1, go to STOP.
  - STOP:
    - TX held 1 for CLKS_PER_BIT cycles.
    - On the last cycle: FGO←1, go to IDLE.
- LD while FGO=0 (any state other than IDLE) is ignored:
  - Data_in is not sampled.
  - The frame in progress is unaffected.
  - Software must poll SKO first.
- LD held high continuously: a new frame starts on the first IDLE cycle after FGO returns to 1. Frames are therefore back-to-back with one idle cycle between them.
- Data_in is sampled only on the accepting edge. Later changes to Data_in do not affect the frame.
- The counter wraps to 0 at CLKS_PER_BIT-1. There is no overflow path.

## Timing
- Acceptance:
  - LD=1 and FGO=1 are sampled at edge k.
  - After edge k: FGO=0, BUSY=1, TX=0.
- Frame length: (u+2)·CLKS_PER_BIT cycles, measured from edge k to the edge where FGO returns to 1.
  - Defaults: 160 cycles.
  - FGO=1 becomes visible after edge k+(u+2)·CLKS_PER_BIT.
- Bit n (0 = start, 1..u = data LSB first, u+1 = stop) occupies cycles k+n·CLKS_PER_BIT through k+(n+1)·CLKS_PER_BIT-1.
- When FGO rises at edge j, an LD at that same edge j is ignored, because FGO was still 0 when sampled. The earliest next acceptance is edge j+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
(CLKS_PER_BIT=4, u=8 unless noted)
- Reset values: assert RST asynchronously between edges. Required response: TX=1, FGO=1, BUSY=0 immediately, before the next edge.
- Single frame: LD=1 for one cycle with Data_in=8'hA5. Required response:
  - TX carries 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - FGO=0 for exactly 40 cycles, then 1.
- Ignored load: after sending 8'h3C, pulse LD at cycle 10 with Data_in=8'hFF. Required response: the transmitted bits are still 0,0,0,1,1,1,1,0,0,1, and FGO timing is unchanged.
- Continuous LD: hold LD=1 with Data_in=8'h01. Required response: frames start every 41 cycles, with exactly one TX=1 idle cycle between each stop bit and the next start bit.
- Reset mid-frame: assert RST during data bit 3 of 8'h00. Required response:
  - TX=1 and FGO=1 immediately.
  - After release, LD with 8'h80 produces a clean full frame 0,0,0,0,0,0,0,0,1,1.
- Parameter sweep: CLKS_PER_BIT=2 with 8'h55, and CLKS_PER_BIT=16 with 8'hAA. Required response: bit widths of 2 and 16 cycles respectively, and frame lengths of 20 and 160 cycles.

Source files
------------

// File: rtl/terminal_tx_if.sv
// rtl/terminal_tx_if.sv - OUT-instruction to terminal transmitter handshake bundle
// Signals:
//   Data_in : character to transmit (AC low byte), driven by the CPU side
//   LD      : OUT-instruction strobe, driven by the CPU side
//   FGO     : output flag, 1 = ready for a new character
//   TX      : serial line, idles high
//   BUSY    : inverse of FGO
interface terminal_tx_if #(
    parameter int u = 8
);
    logic [u-1:0] Data_in;
    logic         LD;
    logic         FGO;
    logic         TX;
    logic         BUSY;

    modport master (
        output Data_in,
        output LD,
        input  FGO,
        input  TX,
        input  BUSY
    );

    modport slave (
        input  Data_in,
        input  LD,
        output FGO,
        output TX,
        output BUSY
    );
endinterface

// File: rtl/terminal_tx.sv
// rtl/terminal_tx.sv - OUTR serializer owning the FGO flag, 8N1 framing
// Ports:
//   CLK : clock, all state changes on its rising edge
//   RST : asynchronous active-high reset
//   bus : terminal_tx_if slave (Data_in, LD in; FGO, TX, BUSY out)
// Frame: start bit (0), u data bits LSB first, one stop bit (1), each bit
// held CLKS_PER_BIT cycles. LD is honoured only while FGO=1.
module terminal_tx #(
    parameter int u            = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         CLK,
    input  logic         RST,
    terminal_tx_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (u > 1) ? $clog2(u) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(u - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state;
    logic [u-1:0]   shift_buf;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  idx;
    logic           fgo;
    logic           tx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            shift_buf <= '0;
            cnt       <= '0;
            idx       <= '0;
            fgo       <= 1'b1;
            tx        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx  <= 1'b1;
                    fgo <= 1'b1;
                    // FGO is already 1 here, so LD is accepted on this edge.
                    if (bus.LD) begin
                        shift_buf <= bus.Data_in;
                        tx        <= 1'b0;
                        fgo       <= 1'b0;
                        cnt       <= '0;
                        idx       <= '0;
                        state     <= START;
                    end
                end

                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        tx    <= shift_buf[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // buf[0] is on the line; buf[1] becomes the next bit.
                            shift_buf <= shift_buf >> 1;
                            tx        <= shift_buf[1];
                            idx       <= idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        fgo   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    fgo   <= 1'b1;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.FGO  = fgo;
    assign bus.TX   = tx;
    assign bus.BUSY = ~fgo;
endmodule

// File: tb/tb_terminal_tx.sv
// tb/tb_terminal_tx.sv - self-checking bench for terminal_tx at three bit rates
module tb_terminal_tx;
    localparam int U  = 8;
    localparam int ND = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic         ld_d   [ND];
    logic [U-1:0] din_d  [ND];
    logic         tx_a   [ND];
    logic         fgo_a  [ND];
    logic         busy_a [ND];

    int compared   = 0;
    int mismatched = 0;
    bit model_on   = 1'b0;

    terminal_tx_if #(.u(U)) if0 ();
    terminal_tx_if #(.u(U)) if1 ();
    terminal_tx_if #(.u(U)) if2 ();

    terminal_tx #(.u(U), .CLKS_PER_BIT(4))  dut0 (.CLK(CLK), .RST(RST), .bus(if0.slave));
    terminal_tx #(.u(U), .CLKS_PER_BIT(2))  dut1 (.CLK(CLK), .RST(RST), .bus(if1.slave));
    terminal_tx #(.u(U), .CLKS_PER_BIT(16)) dut2 (.CLK(CLK), .RST(RST), .bus(if2.slave));

    assign if0.LD = ld_d[0];  assign if0.Data_in = din_d[0];
    assign if1.LD = ld_d[1];  assign if1.Data_in = din_d[1];
    assign if2.LD = ld_d[2];  assign if2.Data_in = din_d[2];
    assign tx_a[0] = if0.TX;  assign fgo_a[0] = if0.FGO;  assign busy_a[0] = if0.BUSY;
    assign tx_a[1] = if1.TX;  assign fgo_a[1] = if1.FGO;  assign busy_a[1] = if1.BUSY;
    assign tx_a[2] = if2.TX;  assign fgo_a[2] = if2.FGO;  assign busy_a[2] = if2.BUSY;

    function automatic int cpb_of(int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 16;
        endcase
    endfunction

    task automatic tally(bit ok, string what);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s", what);
        end
    endtask

    // Reference model: a frame is just "cycles since acceptance"; the line
    // value is picked from the frame bit that offset falls in.
    int           m_t    [ND];
    logic [U-1:0] m_data [ND];
    bit           m_busy [ND];

    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < ND; i++) begin
            if (RST) begin
                m_busy[i] = 1'b0;
                m_t[i]    = 0;
            end else if (!m_busy[i]) begin
                if (ld_d[i] === 1'b1) begin
                    m_busy[i] = 1'b1;
                    m_t[i]    = 0;
                    m_data[i] = din_d[i];
                end
            end else begin
                m_t[i]++;
                if (m_t[i] == (U + 2) * cpb_of(i))
                    m_busy[i] = 1'b0;
            end
        end
    end

    function automatic logic exp_tx(int i);
        int n;
        if (!m_busy[i]) return 1'b1;
        n = m_t[i] / cpb_of(i);
        if (n == 0) return 1'b0;
        if (n <= U) return m_data[i][n-1];
        return 1'b1;
    endfunction

    always @(negedge CLK) begin
        if (model_on) begin
            for (int i = 0; i < ND; i++) begin
                logic et;
                et = exp_tx(i);
                tally(tx_a[i] === et,
                      $sformatf("model dut%0d tx got %b want %b at %0t", i, tx_a[i], et, $time));
                tally(fgo_a[i] === !m_busy[i],
                      $sformatf("model dut%0d fgo got %b want %b at %0t", i, fgo_a[i], !m_busy[i], $time));
                tally(busy_a[i] === m_busy[i],
                      $sformatf("model dut%0d busy got %b want %b at %0t", i, busy_a[i], m_busy[i], $time));
            end
        end
    end

    // seq[n] is the required level of frame bit n (0 = start, 9 = stop).
    task automatic frame_check(int i, logic [U-1:0] data, logic [9:0] seq,
                               int exp_len, int ign_at);
        int         cpb;
        int         total;
        int         lowcnt;
        logic [9:0] bad;
        logic [9:0] mid;
        cpb    = cpb_of(i);
        total  = 10 * cpb;
        lowcnt = 0;
        bad    = '0;
        mid    = '0;
        @(negedge CLK);
        ld_d[i]  = 1'b1;
        din_d[i] = data;
        @(negedge CLK);
        ld_d[i]  = 1'b0;
        din_d[i] = ~data;
        for (int t = 0; t < total; t++) begin
            if (t > 0) @(negedge CLK);
            if (t == ign_at) begin
                ld_d[i]  = 1'b1;
                din_d[i] = '1;
            end else if (t == ign_at + 1) begin
                ld_d[i] = 1'b0;
            end
            if (tx_a[i] !== seq[t / cpb]) bad[t / cpb] = 1'b1;
            if (t % cpb == cpb / 2) mid[t / cpb] = tx_a[i];
            if (fgo_a[i] === 1'b0) lowcnt++;
        end
        for (int n = 0; n < 10; n++)
            tally(!bad[n], $sformatf("dut%0d data %h bit%0d mid-sample %b required %b for all %0d cycles",
                                     i, data, n, mid[n], seq[n], cpb));
        tally(lowcnt == exp_len,
              $sformatf("dut%0d data %h fgo-low cycles got %0d want %0d", i, data, lowcnt, exp_len));
        @(negedge CLK);
        tally(fgo_a[i] === 1'b1,
              $sformatf("dut%0d data %h fgo after frame got %b want 1", i, data, fgo_a[i]));
    endtask

    initial begin
        for (int i = 0; i < ND; i++) begin
            ld_d[i]  = 1'b0;
            din_d[i] = '0;
        end

        // Asynchronous reset between edges: outputs must settle before the next edge.
        #2 RST = 1'b1;
        #1;
        for (int i = 0; i < ND; i++) begin
            tally(tx_a[i] === 1'b1,   $sformatf("reset dut%0d tx got %b want 1", i, tx_a[i]));
            tally(fgo_a[i] === 1'b1,  $sformatf("reset dut%0d fgo got %b want 1", i, fgo_a[i]));
            tally(busy_a[i] === 1'b0, $sformatf("reset dut%0d busy got %b want 0", i, busy_a[i]));
        end
        model_on = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        frame_check(0, 8'hA5, 10'b1101001010, 40, -1);
        frame_check(0, 8'h3C, 10'b1001111000, 40, 10);

        // Held LD: frames every 41 cycles with a single idle-high cycle between.
        begin
            int falls [3];
            int nf;
            int hi_between;
            int hi_tx_ok;
            logic prev;
            falls      = '{-1000, -1000, -1000};
            nf         = 0;
            hi_between = 0;
            hi_tx_ok   = 1;
            @(negedge CLK);
            ld_d[0]  = 1'b1;
            din_d[0] = 8'h01;
            prev     = fgo_a[0];
            for (int t = 0; t < 200 && nf < 3; t++) begin
                @(negedge CLK);
                if (prev === 1'b1 && fgo_a[0] === 1'b0) begin
                    falls[nf] = t;
                    nf++;
                end
                if (nf == 1 && fgo_a[0] === 1'b1) begin
                    hi_between++;
                    if (tx_a[0] !== 1'b1) hi_tx_ok = 0;
                end
                prev = fgo_a[0];
            end
            tally(falls[1] - falls[0] == 41,
                  $sformatf("held-ld period1 got %0d want 41", falls[1] - falls[0]));
            tally(falls[2] - falls[1] == 41,
                  $sformatf("held-ld period2 got %0d want 41", falls[2] - falls[1]));
            tally(hi_between == 1,
                  $sformatf("held-ld idle cycles got %0d want 1", hi_between));
            tally(hi_tx_ok == 1, $sformatf("held-ld idle tx high got %0d want 1", hi_tx_ok));
            ld_d[0] = 1'b0;
            for (int t = 0; t < 100 && fgo_a[0] !== 1'b1; t++) @(negedge CLK);
            tally(fgo_a[0] === 1'b1, $sformatf("held-ld drain fgo got %b want 1", fgo_a[0]));
            @(negedge CLK);
        end

        // Reset during data bit 3 of 8'h00 (frame bit 4, offsets 16..19).
        @(negedge CLK);
        ld_d[0]  = 1'b1;
        din_d[0] = 8'h00;
        @(negedge CLK);
        ld_d[0] = 1'b0;
        repeat (17) @(negedge CLK);
        tally(tx_a[0] === 1'b0, $sformatf("pre-reset mid-frame tx got %b want 0", tx_a[0]));
        #1 RST = 1'b1;
        #1;
        tally(tx_a[0] === 1'b1,   $sformatf("midreset tx got %b want 1", tx_a[0]));
        tally(fgo_a[0] === 1'b1,  $sformatf("midreset fgo got %b want 1", fgo_a[0]));
        tally(busy_a[0] === 1'b0, $sformatf("midreset busy got %b want 0", busy_a[0]));
        @(negedge CLK);
        RST = 1'b0;
        frame_check(0, 8'h80, 10'b1100000000, 40, -1);

        frame_check(1, 8'h55, 10'b1010101010, 20, -1);
        frame_check(2, 8'hAA, 10'b1101010100, 160, -1);

        repeat (3) @(negedge CLK);
        model_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared %0d mismatched %0d", compared, mismatched);
        $fatal(1, "timeout");
    end
endmodule
